// File: rtl/call_stack_pkg.sv
// Shared types and modular pointer helpers for the parametrised return-address stack.
package call_stack_pkg;

  typedef enum logic [1:0] {
    STK_IDLE    = 2'b00,
    STK_POP     = 2'b01,
    STK_PUSH    = 2'b10,
    STK_REPLACE = 2'b11
  } stk_op_e;

  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

  function automatic int ptr_dec(input int ptr, input int depth);
    return (ptr == 0) ? depth - 1 : ptr - 1;
  endfunction

  // Slot holding the entry 'off' places below the top; the 2*depth bias keeps the sum non-negative.
  function automatic int ptr_sub(input int ptr, input int off, input int depth);
    return (ptr - 1 - off + 2 * depth) % depth;
  endfunction

endpackage

// File: rtl/stack_regfile.sv
// DEPTH x WIDTH storage: one synchronous write port, combinational top and (with CALL_STACK_PEEK_EN) peek reads.
module stack_regfile #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_topAddr,
  output logic [WIDTH-1:0] o_topData
`ifdef CALL_STACK_PEEK_EN
  ,
  input  logic [AW-1:0]    i_peekAddr,
  output logic [WIDTH-1:0] o_peekData
`endif
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Contents are deliberately not reset; the top-level masks reads while the stack is empty.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_topData = r_mem[i_topAddr];
`ifdef CALL_STACK_PEEK_EN
  assign o_peekData = r_mem[i_peekAddr];
`endif

endmodule

// File: rtl/call_stack_param.sv
// Parametrised return-address stack with saturate/wrap overflow, sticky flags and replace-top.
// Optional debugger peek port enabled by defining CALL_STACK_PEEK_EN.
module call_stack_param
  import call_stack_pkg::*;
#(
  parameter int WIDTH     = 11,
  parameter int DEPTH     = 16,
  parameter bit WRAP_MODE = 1'b0,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] top,
  output logic [LW-1:0]    level,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
`ifdef CALL_STACK_PEEK_EN
  ,
  input  logic [PW-1:0]    peek_idx,
  output logic [WIDTH-1:0] peek_data
`endif
);

  logic [PW-1:0]    r_wrPtr;
  logic [LW-1:0]    r_level;
  logic             r_ovf;
  logic             r_unf;

  stk_op_e          w_op;
  logic             w_empty;
  logic             w_full;
  logic [PW-1:0]    w_ptrInc;
  logic [PW-1:0]    w_topAddr;
  logic [WIDTH-1:0] w_topData;
  logic [PW-1:0]    w_nextPtr;
  logic [LW-1:0]    w_nextLevel;
  logic             w_we;
  logic [PW-1:0]    w_waddr;
  logic             w_setOvf;
  logic             w_setUnf;

  assign w_op      = stk_op_e'({push, pop});
  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == LW'(DEPTH));
  assign w_ptrInc  = PW'(ptr_inc(int'(r_wrPtr), DEPTH));
  assign w_topAddr = PW'(ptr_dec(int'(r_wrPtr), DEPTH));

  // Replace on an empty stack degenerates to a plain push; it can never be full there.
  always_comb begin
    w_nextPtr   = r_wrPtr;
    w_nextLevel = r_level;
    w_we        = 1'b0;
    w_waddr     = r_wrPtr;
    w_setOvf    = 1'b0;
    w_setUnf    = 1'b0;
    unique case (w_op)
      STK_PUSH: begin
        if (!w_full) begin
          w_we        = 1'b1;
          w_nextPtr   = w_ptrInc;
          w_nextLevel = r_level + 1'b1;
        end else begin
          w_setOvf = 1'b1;
          if (WRAP_MODE) begin
            w_we      = 1'b1;
            w_nextPtr = w_ptrInc;
          end
        end
      end
      STK_POP: begin
        if (!w_empty) begin
          w_nextPtr   = w_topAddr;
          w_nextLevel = r_level - 1'b1;
        end else begin
          w_setUnf = 1'b1;
        end
      end
      STK_REPLACE: begin
        w_we = 1'b1;
        if (!w_empty) begin
          w_waddr = w_topAddr;
        end else begin
          w_nextPtr   = w_ptrInc;
          w_nextLevel = r_level + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_wrPtr <= w_nextPtr;
      r_level <= w_nextLevel;
      r_ovf   <= w_setOvf | (r_ovf & ~clr_flags);
      r_unf   <= w_setUnf | (r_unf & ~clr_flags);
    end
  end

`ifdef CALL_STACK_PEEK_EN
  logic [PW-1:0]    w_peekAddr;
  logic [WIDTH-1:0] w_peekData;

  assign w_peekAddr = PW'(ptr_sub(int'(r_wrPtr), int'(peek_idx), DEPTH));
  assign peek_data  = (LW'(peek_idx) >= r_level) ? '0 : w_peekData;
`endif

  stack_regfile #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (PW)
  ) u_regfile (
    .clk       (clk),
    .i_we      (w_we & ~rst),
    .i_waddr   (w_waddr),
    .i_wdata   (push_data),
    .i_topAddr (w_topAddr),
    .o_topData (w_topData)
`ifdef CALL_STACK_PEEK_EN
    ,
    .i_peekAddr(w_peekAddr),
    .o_peekData(w_peekData)
`endif
  );

  assign top   = w_empty ? '0 : w_topData;
  assign level = r_level;
  assign empty = w_empty;
  assign full  = w_full;
  assign ovf   = r_ovf;
  assign unf   = r_unf;

endmodule

// File: tb/tb_call_stack_param.sv
// Bench for call_stack_param: a saturating DEPTH=4 stack and a wrapping DEPTH=5 stack share stimulus
// and are compared against an oldest-first array model. Peek checks follow CALL_STACK_PEEK_EN.
module tb_call_stack_param;

  logic        clk = 1'b0;
  logic        rst, push, pop, clr_flags;
  logic [10:0] push_data;

  logic [10:0] top0, top1;
  logic [2:0]  level0, level1;
  logic        empty0, full0, ovf0, unf0;
  logic        empty1, full1, ovf1, unf1;
`ifdef CALL_STACK_PEEK_EN
  logic [1:0]  peekIdx0;
  logic [2:0]  peekIdx1;
  logic [10:0] peekData0, peekData1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  call_stack_param #(.WIDTH(11), .DEPTH(4), .WRAP_MODE(1'b0)) dutSat (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data), .clr_flags(clr_flags),
    .top(top0), .level(level0), .empty(empty0), .full(full0), .ovf(ovf0), .unf(unf0)
`ifdef CALL_STACK_PEEK_EN
    , .peek_idx(peekIdx0), .peek_data(peekData0)
`endif
  );

  call_stack_param #(.WIDTH(11), .DEPTH(5), .WRAP_MODE(1'b1)) dutWrap (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data), .clr_flags(clr_flags),
    .top(top1), .level(level1), .empty(empty1), .full(full1), .ovf(ovf1), .unf(unf1)
`ifdef CALL_STACK_PEEK_EN
    , .peek_idx(peekIdx1), .peek_data(peekData1)
`endif
  );

  // Reference model: entries stored oldest-first, mStk[k][mCnt[k]-1] is the top.
  logic [10:0] mStk [2][8];
  int          mCnt [2];
  bit          mOvf [2];
  bit          mUnf [2];

  function automatic int depthOf(input int k);
    return (k == 0) ? 4 : 5;
  endfunction

  function automatic logic [10:0] modelPeek(input int k, input int idx);
    return (idx < mCnt[k]) ? mStk[k][mCnt[k] - 1 - idx] : 11'h0;
  endfunction

  task automatic modelPush(input int k, input logic [10:0] d, output bit setO);
    setO = 1'b0;
    if (mCnt[k] < depthOf(k)) begin
      mStk[k][mCnt[k]] = d;
      mCnt[k]++;
    end else begin
      setO = 1'b1;
      if (k == 1) begin
        for (int i = 0; i < depthOf(k) - 1; i++) mStk[k][i] = mStk[k][i + 1];
        mStk[k][depthOf(k) - 1] = d;
      end
    end
  endtask

  task automatic modelStep(input logic p, input logic q, input logic [10:0] d, input logic c, input logic r);
    bit setO, setU;
    for (int k = 0; k < 2; k++) begin
      setO = 1'b0;
      setU = 1'b0;
      if (r) begin
        mCnt[k] = 0;
        mOvf[k] = 1'b0;
        mUnf[k] = 1'b0;
      end else begin
        case ({p, q})
          2'b10: modelPush(k, d, setO);
          2'b01: if (mCnt[k] > 0) mCnt[k]--; else setU = 1'b1;
          2'b11: if (mCnt[k] > 0) mStk[k][mCnt[k] - 1] = d; else modelPush(k, d, setO);
          default: ;
        endcase
        mOvf[k] = setO | (mOvf[k] & ~c);
        mUnf[k] = setU | (mUnf[k] & ~c);
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkDut(input int k, input logic [10:0] t, input logic [2:0] l,
                          input logic e, input logic f, input logic o, input logic u);
    checkOutput($sformatf("top%0d", k),   32'(t), 32'(modelPeek(k, 0)));
    checkOutput($sformatf("level%0d", k), 32'(l), 32'(mCnt[k]));
    checkOutput($sformatf("empty%0d", k), 32'(e), 32'(mCnt[k] == 0));
    checkOutput($sformatf("full%0d", k),  32'(f), 32'(mCnt[k] == depthOf(k)));
    checkOutput($sformatf("ovf%0d", k),   32'(o), 32'(mOvf[k]));
    checkOutput($sformatf("unf%0d", k),   32'(u), 32'(mUnf[k]));
  endtask

  task automatic applyStimulus(input logic p, input logic q, input logic [10:0] d, input logic c, input logic r);
    push      = p;
    pop       = q;
    push_data = d;
    clr_flags = c;
    rst       = r;
    @(posedge clk);
    modelStep(p, q, d, c, r);
    #1;
    checkDut(0, top0, level0, empty0, full0, ovf0, unf0);
    checkDut(1, top1, level1, empty1, full1, ovf1, unf1);
`ifdef CALL_STACK_PEEK_EN
    peekIdx0 = 2'($urandom);
    peekIdx1 = 3'($urandom);
    #1;
    checkOutput("peek0", 32'(peekData0), 32'(modelPeek(0, int'(peekIdx0))));
    checkOutput("peek1", 32'(peekData1), 32'(modelPeek(1, int'(peekIdx1))));
`endif
  endtask

  initial begin
    int sel;
    logic p, q, c, r;
    for (int k = 0; k < 2; k++) begin
      mCnt[k] = 0;
      mOvf[k] = 1'b0;
      mUnf[k] = 1'b0;
    end
`ifdef CALL_STACK_PEEK_EN
    peekIdx0 = '0;
    peekIdx1 = '0;
`endif

    applyStimulus(0, 0, 11'h000, 0, 1);

    // Basic LIFO
    applyStimulus(1, 0, 11'h010, 0, 0);
    applyStimulus(1, 0, 11'h020, 0, 0);
    applyStimulus(1, 0, 11'h030, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 11'h000, 0, 0);

    // Overflow: saturate on the 4-deep stack, wrap on the 5-deep one
    applyStimulus(0, 0, 11'h000, 0, 1);
    for (int i = 1; i <= 6; i++) applyStimulus(1, 0, 11'(i), 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 11'h000, 0, 0);

    // Replace, then replace on empty
    applyStimulus(0, 0, 11'h000, 0, 1);
    applyStimulus(1, 0, 11'h100, 0, 0);
    applyStimulus(1, 0, 11'h200, 0, 0);
    applyStimulus(1, 1, 11'h2AA, 0, 0);
    applyStimulus(0, 1, 11'h000, 0, 0);
    applyStimulus(0, 1, 11'h000, 0, 0);
    applyStimulus(1, 1, 11'h055, 0, 0);

    // Flags: set, clear, set-wins-over-clear
    applyStimulus(0, 0, 11'h000, 0, 1);
    applyStimulus(0, 1, 11'h000, 0, 0);
    applyStimulus(0, 0, 11'h000, 1, 0);
    applyStimulus(0, 1, 11'h000, 1, 0);

    // Reset mid-stream, then pushes for peek
    applyStimulus(1, 0, 11'h001, 0, 0);
    applyStimulus(1, 0, 11'h002, 0, 0);
    applyStimulus(1, 0, 11'h003, 0, 1);
    applyStimulus(1, 0, 11'h007, 0, 0);
    applyStimulus(1, 0, 11'h008, 0, 0);
    applyStimulus(1, 0, 11'h009, 0, 0);

    for (int n = 0; n < 800; n++) begin
      sel = int'($urandom_range(0, 99));
      p = (sel < 45) || (sel >= 80 && sel < 90);
      q = (sel >= 45 && sel < 90);
      c = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 59) == 0);
      applyStimulus(p, q, 11'($urandom), c, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
